// File: rtl/fgen_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fgen_pkg
// Purpose  : Shared types and constants for the function-generator sweep
//            sequencer: FSM state encoding, select field widths and the
//            setting-table entry layout {wave, amp, freq, dwell}.
// Revision : 1.0  initial release
// ============================================================================
package fgen_pkg;

    localparam int WAVE_W = 3;
    localparam int AMP_W  = 3;
    localparam int FREQ_W = 2;
    localparam int SEL_W  = WAVE_W + AMP_W + FREQ_W;

    // Default dwell width; the top level may override it per instance.
    localparam int DWELL_W_DEFAULT = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DWELL = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Generator-facing portion of a table entry. A full entry is stored as
    // {sel_t, dwell} with the dwell count in the least significant bits.
    typedef struct packed {
        logic [WAVE_W-1:0] wave;
        logic [AMP_W-1:0]  amp;
        logic [FREQ_W-1:0] freq;
    } sel_t;

endpackage
`default_nettype wire

// File: rtl/fgen_cfg_table.sv
`default_nettype none
// ============================================================================
// Module   : fgen_cfg_table
// Purpose  : ENTRIES x ENTRY_W setting register file. One synchronous write
//            port, one asynchronous read port. Contents are not reset.
// Revision : 1.0  initial release
// ============================================================================
module fgen_cfg_table
    import fgen_pkg::*;
#(
    parameter int ENTRIES = 4,
    parameter int IDX_W   = 2,
    parameter int ENTRY_W = SEL_W + DWELL_W_DEFAULT
) (
    input  logic               clk,
    input  logic               we,
    input  logic [IDX_W-1:0]   waddr,
    input  logic [ENTRY_W-1:0] wdata,
    input  logic [IDX_W-1:0]   raddr,
    output logic [ENTRY_W-1:0] rdata
);

    logic [ENTRY_W-1:0] r_mem [ENTRIES];

    // Table write; no reset so the array maps onto plain storage.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/fgen_sweep_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fgen_sweep_sequencer
// Purpose  : Steps the function generator through a programmable table of
//            (waveform, amplitude, frequency) settings, holding each one for
//            its dwell time and strobing ld_freq whenever a new entry is
//            applied. Supports single-pass and looping sweeps plus abort.
// Revision : 1.0  initial release
// ============================================================================
module fgen_sweep_sequencer
    import fgen_pkg::*;
#(
    parameter int ENTRIES = 4,
    parameter int IDX_W   = 2,
    parameter int DWELL_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               loop_en,
    input  logic [IDX_W:0]     num_entries,
    input  logic               cfg_we,
    input  logic [IDX_W-1:0]   cfg_addr,
    input  logic [WAVE_W-1:0]  cfg_wave,
    input  logic [AMP_W-1:0]   cfg_amp,
    input  logic [FREQ_W-1:0]  cfg_freq,
    input  logic [DWELL_W-1:0] cfg_dwell,
    output logic [WAVE_W-1:0]  wave_sel,
    output logic [AMP_W-1:0]   amp_sel,
    output logic [FREQ_W-1:0]  freq_sel,
    output logic               ld_freq,
    output logic [IDX_W-1:0]   cur_idx,
    output logic               busy,
    output logic               done
);

    localparam int ENTRY_W = SEL_W + DWELL_W;

    state_t               r_state;
    state_t               w_state_next;
    logic [IDX_W-1:0]     r_idx;
    logic [DWELL_W-1:0]   r_dwell_cnt;
    sel_t                 r_sel;

    logic                 w_load;
    logic [IDX_W-1:0]     w_load_idx;
    logic [ENTRY_W-1:0]   w_wr_entry;
    logic [ENTRY_W-1:0]   w_rd_entry;
    sel_t                 w_rd_sel;
    logic [DWELL_W-1:0]   w_rd_dwell;
    logic [IDX_W:0]       w_idx_plus1;
    logic                 w_last;
    logic                 w_have_entries;
    logic                 w_dwell_end;

    assign w_wr_entry = {cfg_wave, cfg_amp, cfg_freq, cfg_dwell};

    fgen_cfg_table #(
        .ENTRIES (ENTRIES),
        .IDX_W   (IDX_W),
        .ENTRY_W (ENTRY_W)
    ) u_cfg_table (
        .clk   (clk),
        .we    (cfg_we),
        .waddr (cfg_addr),
        .wdata (w_wr_entry),
        .raddr (w_load_idx),
        .rdata (w_rd_entry)
    );

    assign {w_rd_sel, w_rd_dwell} = w_rd_entry;

    // A ">=" test rather than "==" so that shrinking num_entries below the
    // current position still terminates the pass at this dwell end.
    assign w_idx_plus1    = {1'b0, r_idx} + {{IDX_W{1'b0}}, 1'b1};
    assign w_last         = (w_idx_plus1 >= num_entries);
    assign w_have_entries = (num_entries != '0);
    assign w_dwell_end    = (r_dwell_cnt == '0);

    // Next-state logic. The entry is fetched and latched on the edge that
    // enters LOAD, so selects and ld_freq are valid in the same cycle.
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_load_idx   = '0;
        case (r_state)
            ST_IDLE: begin
                if (!stop && start && w_have_entries) begin
                    w_state_next = ST_LOAD;
                    w_load       = 1'b1;
                end
            end
            ST_LOAD: begin
                w_state_next = stop ? ST_IDLE : ST_DWELL;
            end
            ST_DWELL: begin
                if (stop) begin
                    w_state_next = ST_IDLE;
                end else if (w_dwell_end) begin
                    if (!w_last) begin
                        w_state_next = ST_LOAD;
                        w_load       = 1'b1;
                        w_load_idx   = w_idx_plus1[IDX_W-1:0];
                    end else if (loop_en && w_have_entries) begin
                        // An emptied table cannot wrap; it finishes instead.
                        w_state_next = ST_LOAD;
                        w_load       = 1'b1;
                    end else begin
                        w_state_next = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (stop) begin
                    w_state_next = ST_IDLE;
                end else if (start && w_have_entries) begin
                    w_state_next = ST_LOAD;
                    w_load       = 1'b1;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Entry capture on load, dwell countdown otherwise. A zero dwell is
    // treated as one cycle, so the counter preload is max(dwell,1)-1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx       <= '0;
            r_sel       <= '0;
            r_dwell_cnt <= '0;
        end else if (w_load) begin
            r_idx       <= w_load_idx;
            r_sel       <= w_rd_sel;
            r_dwell_cnt <= (w_rd_dwell == '0) ? '0 : (w_rd_dwell - DWELL_W'(1));
        end else if ((r_state == ST_DWELL) && !w_dwell_end) begin
            r_dwell_cnt <= r_dwell_cnt - DWELL_W'(1);
        end
    end

    assign wave_sel = r_sel.wave;
    assign amp_sel  = r_sel.amp;
    assign freq_sel = r_sel.freq;
    assign cur_idx  = r_idx;
    assign ld_freq  = (r_state == ST_LOAD);
    assign busy     = (r_state == ST_LOAD) || (r_state == ST_DWELL);
    assign done     = (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_fgen_sweep_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fgen_sweep_sequencer
// Purpose  : Directed self-checking bench for fgen_sweep_sequencer.
// Revision : 1.0  initial release
// ============================================================================
module tb_fgen_sweep_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        stop;
    logic        loop_en;
    logic [2:0]  num_entries;
    logic        cfg_we;
    logic [1:0]  cfg_addr;
    logic [2:0]  cfg_wave;
    logic [2:0]  cfg_amp;
    logic [1:0]  cfg_freq;
    logic [15:0] cfg_dwell;
    logic [2:0]  wave_sel;
    logic [2:0]  amp_sel;
    logic [1:0]  freq_sel;
    logic        ld_freq;
    logic [1:0]  cur_idx;
    logic        busy;
    logic        done;

    int vectors     = 0;
    int miscompares = 0;

    fgen_sweep_sequencer #(
        .ENTRIES (4),
        .IDX_W   (2),
        .DWELL_W (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .stop        (stop),
        .loop_en     (loop_en),
        .num_entries (num_entries),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_wave    (cfg_wave),
        .cfg_amp     (cfg_amp),
        .cfg_freq    (cfg_freq),
        .cfg_dwell   (cfg_dwell),
        .wave_sel    (wave_sel),
        .amp_sel     (amp_sel),
        .freq_sel    (freq_sel),
        .ld_freq     (ld_freq),
        .cur_idx     (cur_idx),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    // Advance to just after the next rising edge (sample/drive point).
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_entry(input logic [1:0] a, input logic [2:0] w,
                               input logic [2:0] am, input logic [1:0] f,
                               input logic [15:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wave = w; cfg_amp = am;
        cfg_freq = f; cfg_dwell = d;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 0; stop = 0; loop_en = 0; num_entries = 0;
        cfg_we = 0; cfg_addr = 0; cfg_wave = 0; cfg_amp = 0; cfg_freq = 0; cfg_dwell = 0;
        tick(); tick();
        rst = 1'b0;
        tick();
        vectors++;
        if ({wave_sel, amp_sel, freq_sel, ld_freq, cur_idx} !== 11'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h want 0", {wave_sel, amp_sel, freq_sel, ld_freq, cur_idx});
        end
        vectors++;
        if ({busy, done} !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_busy_done: got %b want 00", {busy, done});
        end
    endtask

    task automatic test_single_pass();
        logic exp_ld, exp_busy, exp_done;
        write_entry(2'd0, 3'd1, 3'd3, 2'd2, 16'd5);
        write_entry(2'd1, 3'd4, 3'd7, 2'd1, 16'd3);
        num_entries = 3'd2; loop_en = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        for (int c = 1; c <= 14; c++) begin
            exp_ld   = (c == 1) || (c == 7);
            exp_done = (c >= 11);
            exp_busy = (c < 11);
            vectors++;
            if ({ld_freq, busy, done} !== {exp_ld, exp_busy, exp_done}) begin
                miscompares++;
                $display("FAIL single_ctrl cyc %0d: ld/busy/done got %b want %b", c,
                         {ld_freq, busy, done}, {exp_ld, exp_busy, exp_done});
            end
            if (c == 1 || c == 5) begin
                vectors++;
                if ({wave_sel, amp_sel, freq_sel, cur_idx} !== {3'd1, 3'd3, 2'd2, 2'd0}) begin
                    miscompares++;
                    $display("FAIL single_entry0 cyc %0d: got %h want %h", c,
                             {wave_sel, amp_sel, freq_sel, cur_idx}, {3'd1, 3'd3, 2'd2, 2'd0});
                end
            end
            if (c == 7 || c == 13) begin
                vectors++;
                if ({wave_sel, amp_sel, freq_sel, cur_idx} !== {3'd4, 3'd7, 2'd1, 2'd1}) begin
                    miscompares++;
                    $display("FAIL single_entry1 cyc %0d: got %h want %h", c,
                             {wave_sel, amp_sel, freq_sel, cur_idx}, {3'd4, 3'd7, 2'd1, 2'd1});
                end
            end
            tick();
        end
        stop = 1'b1; tick(); stop = 1'b0;
        vectors++;
        if ({busy, done} !== 2'b00) begin
            miscompares++;
            $display("FAIL single_stop_done: got %b want 00", {busy, done});
        end
    endtask

    task automatic test_loop();
        logic exp_ld;
        logic [1:0] exp_idx;
        loop_en = 1'b1; num_entries = 3'd2;
        start = 1'b1; tick(); start = 1'b0;
        exp_idx = 2'd0;
        for (int c = 1; c <= 22; c++) begin
            exp_ld = (c == 1) || (c == 7) || (c == 11) || (c == 17) || (c == 21);
            if (c == 7 || c == 17) exp_idx = 2'd1;
            if (c == 11 || c == 21) exp_idx = 2'd0;
            vectors++;
            if ({ld_freq, busy, done, cur_idx} !== {exp_ld, 1'b1, 1'b0, exp_idx}) begin
                miscompares++;
                $display("FAIL loop cyc %0d: ld/busy/done/idx got %b want %b", c,
                         {ld_freq, busy, done, cur_idx}, {exp_ld, 1'b1, 1'b0, exp_idx});
            end
            tick();
        end
        stop = 1'b1; tick(); stop = 1'b0;
        vectors++;
        if ({ld_freq, busy, done} !== 3'b000) begin
            miscompares++;
            $display("FAIL loop_stop: got %b want 000", {ld_freq, busy, done});
        end
    endtask

    task automatic test_dwell_zero();
        logic exp_ld;
        write_entry(2'd0, 3'd2, 3'd2, 2'd1, 16'd0);
        num_entries = 3'd1; loop_en = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            exp_ld = (c % 2) == 1;
            vectors++;
            if ({ld_freq, busy} !== {exp_ld, 1'b1}) begin
                miscompares++;
                $display("FAIL dwell_zero cyc %0d: ld/busy got %b want %b", c,
                         {ld_freq, busy}, {exp_ld, 1'b1});
            end
            tick();
        end
        stop = 1'b1; tick(); stop = 1'b0;
    endtask

    task automatic test_stop_start();
        write_entry(2'd0, 3'd1, 3'd3, 2'd2, 16'd5);
        num_entries = 3'd2; loop_en = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        tick(); tick();
        stop = 1'b1; start = 1'b1; tick(); stop = 1'b0; start = 1'b0;
        for (int c = 0; c < 8; c++) begin
            vectors++;
            if ({ld_freq, busy, done} !== 3'b000) begin
                miscompares++;
                $display("FAIL stop_start_ctrl step %0d: got %b want 000", c, {ld_freq, busy, done});
            end
            vectors++;
            if ({wave_sel, amp_sel, freq_sel, cur_idx} !== {3'd1, 3'd3, 2'd2, 2'd0}) begin
                miscompares++;
                $display("FAIL stop_start_hold step %0d: got %h want %h", c,
                         {wave_sel, amp_sel, freq_sel, cur_idx}, {3'd1, 3'd3, 2'd2, 2'd0});
            end
            tick();
        end
    endtask

    task automatic test_midsweep_write();
        write_entry(2'd1, 3'd4, 3'd7, 2'd1, 16'd3);
        num_entries = 3'd2; loop_en = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        tick();
        write_entry(2'd1, 3'd2, 3'd5, 2'd3, 16'd2);
        vectors++;
        if ({wave_sel, amp_sel, freq_sel} !== {3'd1, 3'd3, 2'd2}) begin
            miscompares++;
            $display("FAIL midwrite_hold: got %h want %h", {wave_sel, amp_sel, freq_sel}, {3'd1, 3'd3, 2'd2});
        end
        for (int c = 3; c < 7; c++) tick();
        vectors++;
        if ({ld_freq, wave_sel, amp_sel, freq_sel, cur_idx} !== {1'b1, 3'd2, 3'd5, 2'd3, 2'd1}) begin
            miscompares++;
            $display("FAIL midwrite_newload: got %h want %h", {ld_freq, wave_sel, amp_sel, freq_sel, cur_idx},
                     {1'b1, 3'd2, 3'd5, 2'd3, 2'd1});
        end
        tick(); tick(); tick();
        vectors++;
        if ({busy, done} !== 2'b01) begin
            miscompares++;
            $display("FAIL midwrite_done: busy/done got %b want 01", {busy, done});
        end
        stop = 1'b1; tick(); stop = 1'b0;
        num_entries = 3'd0;
        start = 1'b1; tick(); start = 1'b0;
        for (int c = 0; c < 3; c++) begin
            vectors++;
            if ({ld_freq, busy, done} !== 3'b000) begin
                miscompares++;
                $display("FAIL zero_entries step %0d: got %b want 000", c, {ld_freq, busy, done});
            end
            tick();
        end
    endtask

    task automatic test_async_reset();
        num_entries = 3'd2; loop_en = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        tick(); tick();
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL async_pre busy: got %b want 1", busy);
        end
        #2 rst = 1'b1;
        #1;
        vectors++;
        if ({wave_sel, amp_sel, freq_sel, ld_freq, cur_idx, busy, done} !== 13'd0) begin
            miscompares++;
            $display("FAIL async_reset: got %h want 0",
                     {wave_sel, amp_sel, freq_sel, ld_freq, cur_idx, busy, done});
        end
        tick();
        rst = 1'b0;
        tick(); tick();
        vectors++;
        if ({ld_freq, busy, done} !== 3'b000) begin
            miscompares++;
            $display("FAIL async_after: got %b want 000", {ld_freq, busy, done});
        end
    endtask

    initial begin
        test_reset();
        test_single_pass();
        test_loop();
        test_dwell_zero();
        test_stop_start();
        test_midsweep_write();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
